// File: rtl/instr_fetch.sv
// instr_fetch: instruction fetch stage.
//   Holds the program counter and a small writable instruction memory, and
//   presents one instruction at a time to decode through a valid/stall
//   handshake. Supports free-run (run) and single-step (step rising edge)
//   operation, and stops for good once the halt word is consumed.
//   The program-load port writes memory while the stage is in IDLE or HALT.
//
// Ports
//   clk          in   rising-edge clock
//   rst          in   synchronous reset, active high
//   run          in   level, fetch continuously
//   step         in   level, each rising edge fetches one instruction
//   stall        in   decode not ready, hold the presented instruction
//   load_en      in   write load_data to memory at load_addr
//   load_addr    in   program-load address
//   load_data    in   program-load data
//   instr        out  instruction presented to decode
//   instr_valid  out  instr is valid this cycle
//   pc           out  address of the current/next instruction
//   halted       out  halt word consumed, fetch stopped
module instr_fetch #(
    parameter int                 IMEM_DEPTH = 16,
    parameter int                 ADDR_W     = 4,
    parameter int                 INSTR_W    = 16,
    parameter logic [INSTR_W-1:0] HALT_WORD  = 16'hFFFF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               run,
    input  logic               step,
    input  logic               stall,
    input  logic               load_en,
    input  logic [ADDR_W-1:0]  load_addr,
    input  logic [INSTR_W-1:0] load_data,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    output logic [ADDR_W-1:0]  pc,
    output logic               halted
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        ISSUE,
        HALT
    } state_t;

    state_t state, state_nxt;

    logic [INSTR_W-1:0] mem [IMEM_DEPTH];

    logic step_q;
    logic step_rise;
    logic addr_ok;
    logic mem_we;
    logic do_fetch;
    logic do_consume;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(IMEM_DEPTH - 1);

    assign step_rise = step & ~step_q;

    // Compare one bit wider so a depth of exactly 2**ADDR_W does not wrap to 0.
    assign addr_ok = ({1'b0, load_addr} < (ADDR_W + 1)'(IMEM_DEPTH));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                // A load in the same cycle takes priority over starting a fetch.
                if (!load_en && (run || step_rise)) begin
                    state_nxt = FETCH;
                end
            end
            FETCH: begin
                state_nxt = ISSUE;
            end
            ISSUE: begin
                if (!stall) begin
                    if (instr == HALT_WORD) begin
                        state_nxt = HALT;
                    end else if (run) begin
                        state_nxt = FETCH;
                    end else begin
                        state_nxt = IDLE;
                    end
                end
            end
            HALT: begin
                state_nxt = HALT;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Output / control decode
    always_comb begin
        mem_we     = 1'b0;
        do_fetch   = 1'b0;
        do_consume = 1'b0;
        unique case (state)
            IDLE:    mem_we     = load_en && addr_ok;
            FETCH:   do_fetch   = 1'b1;
            ISSUE:   do_consume = !stall;
            HALT:    mem_we     = load_en && addr_ok;
            default: ;
        endcase
    end

    // Instruction memory: not cleared by reset.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[load_addr] <= load_data;
        end
    end

    // Step edge detector runs in every state, including HALT.
    always_ff @(posedge clk) begin
        if (rst) begin
            step_q <= 1'b0;
        end else begin
            step_q <= step;
        end
    end

    // Fetch datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            pc          <= '0;
            instr       <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
        end else begin
            if (do_fetch) begin
                instr       <= mem[pc];
                instr_valid <= 1'b1;
            end
            if (do_consume) begin
                instr_valid <= 1'b0;
                if (instr == HALT_WORD) begin
                    halted <= 1'b1;
                end else if (pc == LAST_ADDR) begin
                    pc <= '0;
                end else begin
                    pc <= pc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

    localparam int          DEPTH = 5;
    localparam int          AW    = 4;
    localparam int          IW    = 16;
    localparam logic [15:0] HALTW = 16'hFFFF;

    logic          clk = 1'b0;
    logic          rst;
    logic          run;
    logic          step;
    logic          stall;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [IW-1:0] load_data;
    logic [IW-1:0] instr;
    logic          instr_valid;
    logic [AW-1:0] pc;
    logic          halted;

    logic stall_force = 1'b0;
    logic stall_en    = 1'b0;
    logic stall_rnd   = 1'b0;
    assign stall = stall_force | (stall_en & stall_rnd);

    instr_fetch #(
        .IMEM_DEPTH(DEPTH),
        .ADDR_W    (AW),
        .INSTR_W   (IW),
        .HALT_WORD (HALTW)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .run        (run),
        .step       (step),
        .stall      (stall),
        .load_en    (load_en),
        .load_addr  (load_addr),
        .load_data  (load_data),
        .instr      (instr),
        .instr_valid(instr_valid),
        .pc         (pc),
        .halted     (halted)
    );

    always #5 clk = ~clk;

    int cycle = 0;
    always @(posedge clk) cycle <= cycle + 1;

    // Reference model: program image, next address, halt flag
    typedef struct {
        logic [IW-1:0] instr;
        logic [AW-1:0] pc;
    } exp_t;

    logic [IW-1:0] mdl_mem [DEPTH];
    int            mdl_pc     = 0;
    bit            mdl_halted = 1'b0;
    exp_t          expq[$];

    int checks = 0;
    int errors = 0;

    bit gap_en    = 1'b0;
    int last_pres = -1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name);
        checks++;
        errors++;
        $display("FAIL %s timed out (t=%0t)", name, $time);
    endtask

    function automatic logic [IW-1:0] rand_word();
        return IW'($urandom_range(0, 32'hFFFE));
    endfunction

    // One consumed instruction: queue what decode should see, advance the model
    function automatic void predict_one();
        exp_t e;
        if (mdl_halted) return;
        e.instr = mdl_mem[mdl_pc];
        e.pc    = AW'(mdl_pc);
        expq.push_back(e);
        if (e.instr == HALTW) mdl_halted = 1'b1;
        else mdl_pc = (mdl_pc + 1) % DEPTH;
    endfunction

    // Random stall source, only used while stall_en is set
    initial begin
        forever begin
            @(posedge clk);
            #1;
            stall_rnd = ($urandom_range(0, 2) == 0);
        end
    end

    // Monitor: handshake rules and scoreboard pop on every new presentation
    initial begin
        logic          se, re, pv;
        logic [IW-1:0] pi;
        logic [AW-1:0] pp;
        exp_t          e;
        pv = 1'b0;
        pi = '0;
        pp = '0;
        forever begin
            @(posedge clk);
            se = stall;
            re = rst;
            @(negedge clk);
            if (!re) begin
                if (pv) begin
                    chk("valid_after_issue_cycle", {31'd0, instr_valid}, {31'd0, se});
                    if (se) begin
                        chk("stall_instr_hold", {16'd0, instr}, {16'd0, pi});
                        chk("stall_pc_hold", {28'd0, pc}, {28'd0, pp});
                    end
                end
                if (instr_valid && !pv) begin
                    if (gap_en && last_pres >= 0) chk("issue_gap", cycle - last_pres, 2);
                    last_pres = cycle;
                    if (expq.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL unexpected_issue actual instr=%h pc=%0d required no issue (t=%0t)",
                                 instr, pc, $time);
                    end else begin
                        e = expq.pop_front();
                        chk("issue_instr", {16'd0, instr}, {16'd0, e.instr});
                        chk("issue_pc", {28'd0, pc}, {28'd0, e.pc});
                    end
                end
            end
            pv = instr_valid;
            pi = instr;
            pp = pc;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        mdl_pc     = 0;
        mdl_halted = 1'b0;
        expq.delete();
        chk("rst_instr_valid", {31'd0, instr_valid}, 0);
        chk("rst_pc", {28'd0, pc}, 0);
        chk("rst_halted", {31'd0, halted}, 0);
        chk("rst_instr", {16'd0, instr}, 0);
    endtask

    task automatic load(input int addr, input logic [IW-1:0] data);
        load_en   = 1'b1;
        load_addr = AW'(addr);
        load_data = data;
        tick(1);
        load_en = 1'b0;
        if (addr < DEPTH) mdl_mem[addr] = data;
    endtask

    task automatic wait_idle();
        bit ok = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (expq.size() == 0 && !instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) fail_now("wait_idle");
        tick(4);
    endtask

    task automatic wait_valid();
        bit ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (instr_valid) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) fail_now("wait_valid");
    endtask

    // Run until the halt word is consumed
    task automatic run_to_halt(input bit stall_on);
        bit ok = 1'b0;
        for (int i = 0; i <= DEPTH && !mdl_halted; i++) predict_one();
        stall_en  = stall_on;
        gap_en    = !stall_on;
        last_pres = -1;
        run       = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if (halted) begin
                ok = 1'b1;
                break;
            end
            tick(1);
        end
        if (!ok) fail_now("wait_halted");
        run      = 1'b0;
        stall_en = 1'b0;
        gap_en   = 1'b0;
        tick(3);
        chk("halt_flag", {31'd0, halted}, 1);
        chk("halt_pc", {28'd0, pc}, mdl_pc);
        chk("halt_valid_low", {31'd0, instr_valid}, 0);
        chk("halt_queue_drained", expq.size(), 0);
    endtask

    // Run k instructions of a halt-free program, dropping run while the k-th is presented
    task automatic run_k(input int k, input bit stall_on, input bit load_first, input logic [IW-1:0] ld);
        int cnt  = 0;
        bit prev = 1'b0;
        bit done = 1'b0;
        if (load_first) begin
            load_en   = 1'b1;
            load_addr = AW'(mdl_pc);
            load_data = ld;
            mdl_mem[mdl_pc] = ld;
        end
        for (int i = 0; i < k; i++) predict_one();
        stall_en  = stall_on;
        gap_en    = !stall_on;
        last_pres = -1;
        run       = 1'b1;
        for (int i = 0; i < 40 * k; i++) begin
            tick(1);
            load_en = 1'b0;
            if (instr_valid && !prev) cnt++;
            prev = instr_valid;
            if (cnt == k) begin
                done = 1'b1;
                break;
            end
        end
        run = 1'b0;
        if (!done) fail_now("run_k");
        stall_en = 1'b0;
        gap_en   = 1'b0;
        wait_idle();
        chk("run_k_pc", {28'd0, pc}, mdl_pc);
    endtask

    task automatic step_n(input int n, input bit stall_on);
        stall_en = stall_on;
        for (int i = 0; i < n; i++) begin
            predict_one();
            step = 1'b1;
            tick(5);
            step = 1'b0;
            tick(1);
            wait_idle();
            chk("step_pc", {28'd0, pc}, mdl_pc);
        end
        stall_en = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int       p0;
        int       cnt;
        bit       prev;
        int       h;
        logic [IW-1:0] junk;

        rst       = 1'b1;
        run       = 1'b0;
        step      = 1'b0;
        load_en   = 1'b0;
        load_addr = '0;
        load_data = '0;
        tick(3);
        do_reset();

        // Small program ending in halt, free-run with no stall
        load(0, 16'h0040);
        load(1, 16'h0091);
        load(2, HALTW);
        load(3, rand_word());
        load(4, rand_word());
        run_to_halt(1'b0);
        chk("prog1_halt_pc", {28'd0, pc}, 2);

        // In HALT: run/step ignored, loads still honoured
        step = 1'b1;
        tick(3);
        step = 1'b0;
        run  = 1'b1;
        tick(6);
        run = 1'b0;
        load(2, 16'h1234);
        load(4, rand_word());
        tick(2);
        chk("halt_sticky", {31'd0, halted}, 1);
        chk("halt_sticky_pc", {28'd0, pc}, 2);

        // Single step from reset, three edges
        do_reset();
        step_n(3, 1'b0);
        chk("step3_pc", {28'd0, pc}, 3);

        // Hold during stall; load during ISSUE must be ignored
        p0 = mdl_pc;
        predict_one();
        predict_one();
        stall_force = 1'b1;
        run         = 1'b1;
        wait_valid();
        junk      = ~mdl_mem[(p0 + 1) % DEPTH];
        load_en   = 1'b1;
        load_addr = AW'((p0 + 1) % DEPTH);
        load_data = junk;
        tick(1);
        load_en = 1'b0;
        tick(3);
        chk("stall_pc", {28'd0, pc}, p0);
        chk("stall_valid", {31'd0, instr_valid}, 1);
        stall_force = 1'b0;
        prev = 1'b1;
        cnt  = 0;
        for (int i = 0; i < 20 && cnt == 0; i++) begin
            tick(1);
            if (instr_valid && !prev) cnt++;
            prev = instr_valid;
        end
        run = 1'b0;
        if (cnt == 0) fail_now("second_issue");
        wait_idle();
        chk("after_stall_pc", {28'd0, pc}, mdl_pc);

        // Out-of-range loads must not disturb memory
        for (int a = DEPTH; a < (1 << AW); a++) load(a, rand_word());

        // Load and run in the same IDLE cycle; wrap at DEPTH
        run_k(DEPTH + 1, 1'b0, 1'b1, 16'hBEEF);

        // Reset while stalled in ISSUE
        predict_one();
        stall_force = 1'b1;
        run         = 1'b1;
        wait_valid();
        tick(2);
        run = 1'b0;
        do_reset();
        stall_force = 1'b0;
        run_k(3, 1'b1, 1'b0, '0);

        // Randomised programs with a halt somewhere
        for (int r = 0; r < 6; r++) begin
            do_reset();
            h = $urandom_range(0, DEPTH - 1);
            for (int a = 0; a < DEPTH; a++) load(a, (a == h) ? HALTW : rand_word());
            step_n($urandom_range(1, 4), 1'($urandom_range(0, 1)));
            run_to_halt(1'($urandom_range(0, 1)));
        end

        tick(4);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
